// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_drain
// Brief    : Read-side adapter that turns a registered-read FIFO into a
//            valid/ready stream with a 2-entry skid buffer and burst framing.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_drain #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_en,
    input  logic [WIDTH-1:0] i_fifo_rd_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    localparam int                 c_CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_LEN - 1);

    logic [1:0]         r_occ;
    logic               r_inflight;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_e0;
    logic [WIDTH-1:0]   r_e1;

    logic               w_pop;
    logic [2:0]         w_commit;
    logic [1:0]         w_occ_nxt;
    logic [WIDTH-1:0]   w_e0_nxt;
    logic [WIDTH-1:0]   w_e1_nxt;

    assign w_pop    = o_valid & i_ready;
    // Words held or returning after this edge; a new read is only issued
    // when that leaves a free slot for the word it will return.
    assign w_commit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign o_fifo_rd_en = i_rst_n & ~i_clear & ~i_fifo_empty & (w_commit <= 3'd1);
    assign o_valid      = (r_occ != 2'd0);
    assign o_data       = r_e0;
    assign o_last       = o_valid & (r_cnt == c_CNT_LAST);

    always_comb begin
        w_occ_nxt = r_occ;
        w_e0_nxt  = r_e0;
        w_e1_nxt  = r_e1;
        case ({r_inflight, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_e0_nxt = i_fifo_rd_data;
                end else begin
                    w_e1_nxt = i_fifo_rd_data;
                end
                w_occ_nxt = r_occ + 2'd1;
            end
            2'b01: begin
                w_e0_nxt  = r_e1;
                w_occ_nxt = r_occ - 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd2) begin
                    w_e0_nxt = r_e1;
                    w_e1_nxt = i_fifo_rd_data;
                end else begin
                    w_e0_nxt = i_fifo_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_e0       <= '0;
            r_e1       <= '0;
        end else if (i_clear) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= o_fifo_rd_en;
            r_e0       <= w_e0_nxt;
            r_e1       <= w_e1_nxt;
            if (w_pop) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
